// File: rtl/fb_write_arbiter.sv
// Two-requester round-robin arbiter feeding fill commands to a frame-buffer writer.
// Latency: request sampled in IDLE -> ack in the next cycle -> wr_enable the cycle after that.
// Backpressure: holds in IDLE while wr_valid=0; holds a command until wr_busy, bounded by TIMEOUT.
//
// Ports:
//   clk, rst_n               single clock, asynchronous active-low reset
//   rN_req/x/y/pixel/len     fill request from requester N (N = 0, 1)
//   rN_ack, rN_done          one-cycle pulses: parameters captured / request retired
//   wr_valid, wr_busy        writer ready (memory initialised) / writer busy with a fill
//   wr_enable, wr_x_pos, wr_y_pos, wr_pixel, wr_len   command to the writer
//   grant_id                 requester owning the current transaction
//   err_timeout, err_range   one-cycle error pulses
//
// Optional build macro FB_ARB_CLIP_EN: clamp wr_len so a fill never runs past
// the last pixel of the frame. Without it wr_len is the requested length.

module fb_write_arbiter #(
    parameter int H_DISP  = 1024,
    parameter int V_DISP  = 600,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        r0_req,
    input  logic [15:0] r0_x,
    input  logic [15:0] r0_y,
    input  logic [23:0] r0_pixel,
    input  logic [23:0] r0_len,
    output logic        r0_ack,
    output logic        r0_done,

    input  logic        r1_req,
    input  logic [15:0] r1_x,
    input  logic [15:0] r1_y,
    input  logic [23:0] r1_pixel,
    input  logic [23:0] r1_len,
    output logic        r1_ack,
    output logic        r1_done,

    input  logic        wr_valid,
    input  logic        wr_busy,
    output logic        wr_enable,
    output logic [15:0] wr_x_pos,
    output logic [15:0] wr_y_pos,
    output logic [23:0] wr_pixel,
    output logic [23:0] wr_len,

    output logic        grant_id,
    output logic        err_timeout,
    output logic        err_range
);

    // The counter only has to reach TIMEOUT-1: the edge on which it would
    // reach TIMEOUT is the edge that abandons the command.
    localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   H_LIM    = 16'(H_DISP);
    localparam logic [15:0]   V_LIM    = 16'(V_DISP);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        ACTIVE,
        FINISH
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          last_grant;
    logic [TW-1:0] tmo_cnt;

    logic          start;
    logic          tmo_hit;
    logic          sel;
    logic [15:0]   sel_x;
    logic [15:0]   sel_y;
    logic [23:0]   sel_pixel;
    logic [23:0]   sel_len;
    logic [23:0]   cap_len;
    logic          sel_oob;

    // Arbitration and request mux. A lone requester always wins; on a tie
    // the requester that did not own the previous transaction wins.
    always_comb begin
        sel       = (r0_req && r1_req) ? ~last_grant : r1_req;
        sel_x     = sel ? r1_x     : r0_x;
        sel_y     = sel ? r1_y     : r0_y;
        sel_pixel = sel ? r1_pixel : r0_pixel;
        sel_len   = sel ? r1_len   : r0_len;
        sel_oob   = (sel_x >= H_LIM) || (sel_y >= V_LIM);
    end

`ifdef FB_ARB_CLIP_EN
    localparam logic [23:0] FRAME_PIX = 24'(H_DISP * V_DISP);
    localparam logic [23:0] H_PIX     = 24'(H_DISP);

    logic [23:0] offset;
    logic [23:0] room;

    // Pixels left between the start position and the end of the frame.
    // Meaningless for an out-of-range start, but that request never issues.
    always_comb begin
        offset  = {8'd0, sel_x} + ({8'd0, sel_y} * H_PIX);
        room    = FRAME_PIX - offset;
        cap_len = (sel_len > room) ? room : sel_len;
    end
`else
    assign cap_len = sel_len;
`endif

    assign start = wr_valid && (r0_req || r1_req);

    // Next-state logic. In GRANT err_range doubles as the captured
    // out-of-range flag, since it is high exactly for that cycle.
    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (err_range || (wr_len == 24'd0)) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Busy wins over timeout, and busy already high on entry
                // counts as acceptance.
                if (wr_busy) begin
                    state_nxt = ACTIVE;
                end else if (wr_valid && (tmo_cnt == TMO_LAST)) begin
                    state_nxt = FINISH;
                    tmo_hit   = 1'b1;
                end
            end
            ACTIVE: begin
                if (!wr_busy) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            tmo_cnt     <= '0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            r0_done     <= 1'b0;
            r1_done     <= 1'b0;
            wr_enable   <= 1'b0;
            wr_x_pos    <= '0;
            wr_y_pos    <= '0;
            wr_pixel    <= '0;
            wr_len      <= '0;
            grant_id    <= 1'b0;
            err_timeout <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            state <= state_nxt;

            // Capture on the IDLE->GRANT edge so the command, owner and
            // range flag are all valid during the ack cycle; requester
            // inputs are not looked at again.
            r0_ack    <= (state == IDLE) && start && !sel;
            r1_ack    <= (state == IDLE) && start &&  sel;
            err_range <= (state == IDLE) && start && sel_oob;
            if ((state == IDLE) && start) begin
                grant_id <= sel;
                wr_x_pos <= sel_x;
                wr_y_pos <= sel_y;
                wr_pixel <= sel_pixel;
                wr_len   <= cap_len;
            end

            wr_enable   <= (state_nxt == ISSUE);
            err_timeout <= tmo_hit;
            r0_done     <= (state_nxt == FINISH) && !grant_id;
            r1_done     <= (state_nxt == FINISH) &&  grant_id;

            if (state == FINISH) begin
                last_grant <= grant_id;
            end

            // Wait counter runs only while the writer reports ready.
            if (state_nxt != ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == ISSUE) && wr_valid) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
`timescale 1ns/1ps
module tb_fb_write_arbiter;

    localparam int TMO = 16;
    localparam int K_NORMAL = 0;
    localparam int K_ZERO   = 1;
    localparam int K_RANGE  = 2;
    localparam int K_TMO    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [15:0] r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
    logic [23:0] r0_pixel = '0, r0_len = '0, r1_pixel = '0, r1_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_busy = 1'b0;
    logic        r0_ack, r0_done, r1_ack, r1_done;
    logic        wr_enable;
    logic [15:0] wr_x_pos, wr_y_pos;
    logic [23:0] wr_pixel, wr_len;
    logic        grant_id, err_timeout, err_range;

    fb_write_arbiter #(.H_DISP(1024), .V_DISP(600), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_x(r0_x), .r0_y(r0_y), .r0_pixel(r0_pixel), .r0_len(r0_len),
        .r0_ack(r0_ack), .r0_done(r0_done),
        .r1_req(r1_req), .r1_x(r1_x), .r1_y(r1_y), .r1_pixel(r1_pixel), .r1_len(r1_len),
        .r1_ack(r1_ack), .r1_done(r1_done),
        .wr_valid(wr_valid), .wr_busy(wr_busy), .wr_enable(wr_enable),
        .wr_x_pos(wr_x_pos), .wr_y_pos(wr_y_pos), .wr_pixel(wr_pixel), .wr_len(wr_len),
        .grant_id(grant_id), .err_timeout(err_timeout), .err_range(err_range)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          id;
        logic [15:0] x;
        logic [15:0] y;
        logic [23:0] pix;
        logic [23:0] len;
        int          kind;
    } txn_t;

    txn_t expq[$];
    bit   m_lg = 1'b1;   // owner of the previous transaction; r0 wins the first tie

    function automatic logic [23:0] exp_len(input int x, input int y, input int len);
`ifdef FB_ARB_CLIP_EN
        int room;
        room = 1024 * 600 - (x + y * 1024);
        if (x < 1024 && y < 600 && len > room) return 24'(room);
`endif
        return 24'(len);
    endfunction

    task automatic push_exp(input bit id, input int x, input int y, input int pix, input int len, input bit tmo);
        txn_t t;
        t.id  = id;
        t.x   = 16'(x);
        t.y   = 16'(y);
        t.pix = 24'(pix);
        t.len = exp_len(x, y, len);
        if (x >= 1024 || y >= 600) t.kind = K_RANGE;
        else if (t.len == 24'd0)   t.kind = K_ZERO;
        else if (tmo)              t.kind = K_TMO;
        else                       t.kind = K_NORMAL;
        expq.push_back(t);
    endtask

    // ---------------- writer model ----------------
    bit wmode = 1'b1;     // 0: busy stuck low
    int busy_delay = 3;
    int busy_len = 200;

    initial begin : writer
        int wph;
        int wcnt;
        wph = 0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                wr_busy = 1'b0;
                wph = 0;
            end else if (!wmode) begin
                wr_busy = 1'b0;
            end else begin
                case (wph)
                    0: if (wr_enable && !wr_busy) begin wph = 1; wcnt = 0; end
                    1: begin
                        wcnt++;
                        if (wcnt >= busy_delay) begin wr_busy = 1'b1; wph = 2; wcnt = 0; end
                    end
                    default: begin
                        wcnt++;
                        if (wcnt >= busy_len) begin wr_busy = 1'b0; wph = 0; end
                    end
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    int   acks[2];
    int   dones[2];
    int   ack_log[$];
    int   cyc = 0, ack_cyc = 0, done_cyc = 0, en_cycles = 0, rng_cnt = 0, tmo_seen = 0;
    logic [23:0] en_len = '0;
    txn_t cur;
    bit   cur_act = 1'b0, prev_en = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            expq.delete();
            cur_act = 1'b0;
            prev_en = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (r0_ack || r1_ack) begin
                chk("ack_onehot", 32'(r0_ack & r1_ack), 0);
                if (expq.size() == 0 || cur_act) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got r0_ack=%0b r1_ack=%0b expected no ack", r0_ack, r1_ack);
                end else begin
                    cur = expq.pop_front();
                    cur_act = 1'b1;
                    en_cycles = 0;
                    ack_cyc = cyc;
                    chk("ack_id", 32'(r1_ack), 32'(cur.id));
                    chk("grant_id", 32'(grant_id), 32'(cur.id));
                    acks[r1_ack ? 1 : 0]++;
                    ack_log.push_back(r1_ack ? 1 : 0);
                end
            end
            chk("err_range", 32'(err_range), 32'((r0_ack || r1_ack) && cur_act && cur.kind == K_RANGE));
            if (err_range) rng_cnt++;
            if (wr_enable) begin
                if (!prev_en) begin
                    chk("en_one_after_ack", cyc - ack_cyc, 1);
                    chk("en_allowed", 32'(cur_act && (cur.kind == K_NORMAL || cur.kind == K_TMO)), 1);
                    en_len = wr_len;
                end
                chk("wr_x_pos", 32'(wr_x_pos), 32'(cur.x));
                chk("wr_y_pos", 32'(wr_y_pos), 32'(cur.y));
                chk("wr_len", 32'(wr_len), 32'(cur.len));
                en_cycles++;
            end else if (prev_en && cur.kind != K_TMO) begin
                chk("drop_after_busy", 32'(prev_busy), 1);
            end
            if (cur_act) chk("wr_pixel", 32'(wr_pixel), 32'(cur.pix));
            if (r0_done || r1_done) begin
                chk("done_onehot", 32'(r0_done & r1_done), 0);
                if (!cur_act) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got r0_done=%0b r1_done=%0b expected none", r0_done, r1_done);
                end else begin
                    chk("done_id", 32'(r1_done), 32'(cur.id));
                    chk("err_timeout", 32'(err_timeout), 32'(cur.kind == K_TMO));
                    if (cur.kind == K_TMO) chk("tmo_en_cycles", en_cycles, TMO);
                    if (cur.kind == K_ZERO || cur.kind == K_RANGE) chk("no_enable", en_cycles, 0);
                    dones[r1_done ? 1 : 0]++;
                    done_cyc = cyc;
                    cur_act = 1'b0;
                end
            end else begin
                chk("err_timeout_quiet", 32'(err_timeout), 0);
            end
            if (err_timeout) tmo_seen++;
            prev_en = wr_enable;
            prev_busy = wr_busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input bit id, input bit on, input int x, input int y, input int pix, input int len);
        if (id) begin
            r1_req = on; r1_x = 16'(x); r1_y = 16'(y); r1_pixel = 24'(pix); r1_len = 24'(len);
        end else begin
            r0_req = on; r0_x = 16'(x); r0_y = 16'(y); r0_pixel = 24'(pix); r0_len = 24'(len);
        end
    endtask

    task automatic wait_cnt(input bit is_done, input bit id, input int target, input int budget, input string what);
        int k;
        int v;
        k = 0;
        v = is_done ? dones[id] : acks[id];
        while (v < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
            v = is_done ? dones[id] : acks[id];
        end
        checks++;
        if (v < target) begin
            errors++;
            $display("FAIL wait_%s: got count %0d required %0d within %0d cycles", what, v, target, budget);
        end
    endtask

    task automatic txn(input bit id, input int x, input int y, input int pix, input int len, input bit tmo);
        int a;
        int d;
        push_exp(id, x, y, pix, len, tmo);
        m_lg = id;
        a = acks[id];
        d = dones[id];
        set_req(id, 1'b1, x, y, pix, len);
        wait_cnt(1'b0, id, a + 1, 60, "ack");
        set_req(id, 1'b0, x, y, pix, len);
        wait_cnt(1'b1, id, d + 1, 600, "done");
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required to finish");
        $fatal(1);
    end

    initial begin : main
        int a0;
        int a1;
        int d0;
        int d1;
        int k;
        bit nid;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_enable", 32'(wr_enable), 0);
        chk("rst_acks", 32'({r0_ack, r1_ack}), 0);
        chk("rst_dones", 32'({r0_done, r1_done}), 0);
        chk("rst_errs_grant", 32'({err_timeout, err_range, grant_id}), 0);
        chk("rst_wr_len", 32'(wr_len), 0);
        rst_n = 1'b1;

        // wr_valid low keeps the arbiter idle
        push_exp(0, 10, 20, 32'hFF0000, 100, 1'b0);
        m_lg = 1'b0;
        set_req(0, 1'b1, 10, 20, 32'hFF0000, 100);
        repeat (5) @(negedge clk);
        #1;
        chk("hold_idle_acks", acks[0], 0);
        chk("hold_idle_en", 32'(wr_enable), 0);

        // r0 basic fill: writer busy 3 cycles after enable, for 200 cycles
        busy_delay = 3;
        busy_len = 200;
        wr_valid = 1'b1;
        wait_cnt(1'b0, 0, 1, 20, "r0_ack");
        set_req(0, 1'b0, 10, 20, 32'hFF0000, 100);
        wait_cnt(1'b1, 0, 1, 400, "r0_done");
        chk("r0_en_cycles", en_cycles, 4);
        chk("r0_done_latency", done_cyc - ack_cyc, 205);
        chk("r0_done_count", dones[0], 1);
        repeat (2) @(negedge clk);
        #1;

        // Reset while the command is outstanding
        busy_delay = 10;
        busy_len = 3;
        push_exp(1, 5, 5, 32'h00FF00, 50, 1'b0);
        d1 = dones[1];
        set_req(1, 1'b1, 5, 5, 32'h00FF00, 50);
        wait_cnt(1'b0, 1, acks[1] + 1, 20, "mid_ack");
        set_req(1, 1'b0, 5, 5, 32'h00FF00, 50);
        repeat (2) @(negedge clk);
        #1;
        chk("pre_reset_en", 32'(wr_enable), 1);
        rst_n = 1'b0;
        m_lg = 1'b1;
        #1;
        chk("async_rst_en", 32'(wr_enable), 0);
        chk("async_rst_grant", 32'(grant_id), 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("no_done_after_reset", dones[1], d1);

        // Both requesters held: grants alternate r0, r1, r0, r1
        busy_delay = 2;
        busy_len = 3;
        ack_log.delete();
        a0 = acks[0]; a1 = acks[1]; d0 = dones[0]; d1 = dones[1];
        for (int i = 0; i < 4; i++) begin
            nid = ~m_lg;
            if (nid) push_exp(1, 70, 80, 32'h222222, 9, 1'b0);
            else     push_exp(0, 50, 60, 32'h111111, 8, 1'b0);
            m_lg = nid;
        end
        set_req(0, 1'b1, 50, 60, 32'h111111, 8);
        set_req(1, 1'b1, 70, 80, 32'h222222, 9);
        k = 0;
        while ((acks[0] + acks[1]) < (a0 + a1 + 4) && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        set_req(0, 1'b0, 50, 60, 32'h111111, 8);
        set_req(1, 1'b0, 70, 80, 32'h222222, 9);
        chk("rr_acks_total", acks[0] + acks[1] - a0 - a1, 4);
        k = 0;
        while ((dones[0] + dones[1]) < (d0 + d1 + 4) && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rr_dones_r0", dones[0] - d0, 2);
        chk("rr_dones_r1", dones[1] - d1, 2);
        chk("rr_order_len", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            chk("rr_order_0", ack_log[0], 0);
            chk("rr_order_1", ack_log[1], 1);
            chk("rr_order_2", ack_log[2], 0);
            chk("rr_order_3", ack_log[3], 1);
        end
        repeat (2) @(negedge clk);
        #1;

        // Zero length: ack then done on the next cycle, no enable
        txn(1, 0, 0, 32'h123456, 0, 1'b0);
        chk("zero_done_latency", done_cyc - ack_cyc, 1);
        chk("zero_en_cycles", en_cycles, 0);

        // Out-of-range x, then out-of-range y
        txn(0, 1024, 0, 32'hABCDEF, 10, 1'b0);
        chk("range_x_pulses", rng_cnt, 1);
        txn(1, 0, 600, 32'hABCDEF, 10, 1'b0);
        chk("range_y_pulses", rng_cnt, 2);

        // Writer never goes busy: abandoned after TIMEOUT cycles
        wmode = 1'b0;
        txn(0, 100, 100, 32'h010203, 20, 1'b1);
        chk("tmo_en_cycles_lit", en_cycles, 16);
        chk("tmo_pulses", tmo_seen, 1);
        wmode = 1'b1;

        // Fill running past the end of the frame
        txn(1, 1000, 599, 32'h0000FF, 100, 1'b0);
`ifdef FB_ARB_CLIP_EN
        chk("clip_len", 32'(en_len), 24);
`else
        chk("clip_len", 32'(en_len), 100);
`endif
        chk("final_queue_empty", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
